// File: rtl/lc_trans_sequencer.sv
// Life cycle transition sequencer: round-robin arbitration of transition
// requests, legality/token check, OTP program handshake with timeout,
// per-request status, and a sticky lock after the first successful transition.
module lc_trans_sequencer #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TOKEN_W     = 32,
  parameter int unsigned OTP_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 lc_state_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [3*NUM_REQ-1:0]       req_target_i,
  input  logic [TOKEN_W*NUM_REQ-1:0] req_token_i,
  input  logic [TOKEN_W-1:0]         exp_token_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       resp_valid_o,
  output logic [2:0]                 resp_err_o,
  output logic                       otp_req_o,
  output logic [2:0]                 otp_state_o,
  input  logic                       otp_ack_i,
  input  logic                       otp_err_i,
  output logic                       busy_o,
  output logic                       locked_o
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(OTP_TIMEOUT + 1);

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_TOKEN   = 3'd2;
  localparam logic [2:0] ERR_OTP     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_LOCKED  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PROG,
    ST_RESP,
    ST_LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [2:0]           tgt_q, tgt_d;
  logic [TOKEN_W-1:0]   tok_q, tok_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 otp_req_q, otp_req_d;
  logic [2:0]           otp_state_q, otp_state_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [2:0]           resp_err_q, resp_err_d;
  logic                 locked_q, locked_d;

  logic                 arb_found;
  logic [PW-1:0]        arb_sel;
  logic [PW-1:0]        arb_cand;
  logic [2:0]           chk_code;

  // Legal transition matrix; illegal pairs win over a token mismatch.
  function automatic logic [2:0] check_trans(input logic [2:0] src,
                                             input logic [2:0] dst,
                                             input logic       tok_ok);
    logic [2:0] r;
    r = ERR_ILLEGAL;
    case (src)
      3'd0: if (dst == 3'd1) r = ERR_OK;
      3'd1: if (dst == 3'd2 || dst == 3'd3) r = ERR_OK;
      3'd2: if (dst == 3'd1 || dst == 3'd3) r = tok_ok ? ERR_OK : ERR_TOKEN;
      default: r = ERR_ILLEGAL;
    endcase
    return r;
  endfunction

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_cand = PW'((32'(ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
  end

  // Outcome of the check on the latched request; lc_state_i only matters here.
  always_comb begin
    chk_code = locked_q ? ERR_LOCKED
                        : check_trans(lc_state_i, tgt_q, tok_q == exp_token_i);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    tgt_d        = tgt_q;
    tok_d        = tok_q;
    cnt_d        = cnt_q;
    otp_req_d    = otp_req_q;
    otp_state_d  = otp_state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = '0;
    locked_d     = locked_q;

    case (state_q)
      ST_IDLE, ST_LOCKED: begin
        // Target and token are latched so a requester dropping its request
        // mid-operation cannot disturb the transaction.
        if (arb_found) begin
          gnt_d   = NUM_REQ'(1) << arb_sel;
          tgt_d   = req_target_i[3*arb_sel +: 3];
          tok_d   = req_token_i[TOKEN_W*arb_sel +: TOKEN_W];
          ptr_d   = (arb_sel == PW'(NUM_REQ - 1)) ? '0 : arb_sel + 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_code == ERR_OK) begin
          otp_req_d   = 1'b1;
          otp_state_d = tgt_q;
          cnt_d       = '0;
          state_d     = ST_PROG;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = chk_code;
          state_d      = ST_RESP;
        end
      end
      ST_PROG: begin
        if (otp_ack_i) begin
          otp_req_d    = 1'b0;
          otp_state_d  = '0;
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = otp_err_i ? ERR_OTP : ERR_OK;
          state_d      = ST_RESP;
        end else if (cnt_q + 1'b1 == CW'(OTP_TIMEOUT)) begin
          otp_req_d    = 1'b0;
          otp_state_d  = '0;
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_TIMEOUT;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        gnt_d = '0;
        if (resp_err_q == ERR_OK || locked_q) begin
          locked_d = 1'b1;
          state_d  = ST_LOCKED;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      ptr_q        <= '0;
      tgt_q        <= '0;
      tok_q        <= '0;
      cnt_q        <= '0;
      otp_req_q    <= 1'b0;
      otp_state_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= '0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      tgt_q        <= tgt_d;
      tok_q        <= tok_d;
      cnt_q        <= cnt_d;
      otp_req_q    <= otp_req_d;
      otp_state_q  <= otp_state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      locked_q     <= locked_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign otp_req_o    = otp_req_q;
  assign otp_state_o  = otp_state_q;
  assign locked_o     = locked_q;
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_LOCKED);

endmodule

// File: tb/tb_lc_trans_sequencer.sv
// Directed bench for lc_trans_sequencer with hand-computed expectations.
module tb_lc_trans_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  lc_state_i;
  logic [1:0]  req_valid_i;
  logic [5:0]  req_target_i;
  logic [63:0] req_token_i;
  logic [31:0] exp_token_i;
  logic [1:0]  gnt_o;
  logic        resp_valid_o;
  logic [2:0]  resp_err_o;
  logic        otp_req_o;
  logic [2:0]  otp_state_o;
  logic        otp_ack_i;
  logic        otp_err_i;
  logic        busy_o;
  logic        locked_o;

  int checks = 0;
  int errors = 0;
  int n;

  lc_trans_sequencer #(
    .NUM_REQ    (2),
    .TOKEN_W    (32),
    .OTP_TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lc_state_i  (lc_state_i),
    .req_valid_i (req_valid_i),
    .req_target_i(req_target_i),
    .req_token_i (req_token_i),
    .exp_token_i (exp_token_i),
    .gnt_o       (gnt_o),
    .resp_valid_o(resp_valid_o),
    .resp_err_o  (resp_err_o),
    .otp_req_o   (otp_req_o),
    .otp_state_o (otp_state_o),
    .otp_ack_i   (otp_ack_i),
    .otp_err_i   (otp_err_i),
    .busy_o      (busy_o),
    .locked_o    (locked_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    lc_state_i   = 3'd0;
    req_valid_i  = 2'b00;
    req_target_i = '0;
    req_token_i  = '0;
    exp_token_i  = 32'hBEEF_0001;
    otp_ack_i    = 1'b0;
    otp_err_i    = 1'b0;

    // Reset state
    do_reset();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_err", resp_err_o, 0);
    chk("rst_otp_req", otp_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_locked", locked_o, 0);

    // Arbitration: both Raw->TestUnlocked0, req0 wins, OTP acks on 3rd PROG cycle
    lc_state_i   = 3'd0;
    req_target_i = {3'd1, 3'd1};
    req_valid_i  = 2'b11;
    step();
    chk("arb_gnt", gnt_o, 2'b01);
    chk("arb_busy", busy_o, 1);
    step();
    chk("arb_otp_req", otp_req_o, 1);
    chk("arb_otp_state", otp_state_o, 1);
    step();
    step();
    otp_ack_i = 1'b1;
    step();
    otp_ack_i   = 1'b0;
    req_valid_i = 2'b10;
    chk("arb_resp_valid", resp_valid_o, 1);
    chk("arb_resp_err", resp_err_o, 0);
    chk("arb_otp_drop", otp_req_o, 0);
    chk("arb_gnt_hold", gnt_o, 2'b01);
    step();
    chk("arb_gnt_clr", gnt_o, 0);
    chk("arb_locked", locked_o, 1);
    chk("arb_err_clr", resp_err_o, 0);
    chk("arb_busy_locked", busy_o, 0);

    // Locked: req1 still waiting gets LOCKED with no OTP activity
    step();
    chk("lk_gnt", gnt_o, 2'b10);
    step();
    chk("lk_resp_valid", resp_valid_o, 1);
    chk("lk_resp_err", resp_err_o, 5);
    chk("lk_otp_req", otp_req_o, 0);
    req_valid_i = 2'b00;
    step();
    chk("lk_gnt_clr", gnt_o, 0);
    chk("lk_locked", locked_o, 1);

    // After reset the pointer restarts at 0; then reset mid-PROG
    do_reset();
    chk("rr_locked_clr", locked_o, 0);
    req_valid_i = 2'b11;
    step();
    chk("rr_gnt_after_rst", gnt_o, 2'b01);
    step();
    chk("rstprog_otp_req", otp_req_o, 1);
    rst_n       = 1'b0;
    req_valid_i = 2'b00;
    step();
    chk("rstprog_otp_drop", otp_req_o, 0);
    chk("rstprog_gnt", gnt_o, 0);
    chk("rstprog_resp", resp_valid_o, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("rstprog_busy", busy_o, 0);
    chk("rstprog_resp2", resp_valid_o, 0);
    chk("rstprog_locked", locked_o, 0);

    // Illegal: Raw -> Rma (pointer at 0 after reset)
    lc_state_i   = 3'd0;
    req_target_i = {3'd0, 3'd3};
    req_valid_i  = 2'b01;
    step();
    chk("ill_gnt", gnt_o, 2'b01);
    chk("ill_otp_req0", otp_req_o, 0);
    step();
    chk("ill_resp_valid", resp_valid_o, 1);
    chk("ill_resp_err", resp_err_o, 1);
    chk("ill_otp_req1", otp_req_o, 0);
    req_valid_i = 2'b00;
    step();
    chk("ill_gnt_clr", gnt_o, 0);
    chk("ill_busy", busy_o, 0);
    chk("ill_locked", locked_o, 0);

    // Token gate: TestLocked0 -> Rma with wrong token (pointer now 1, req1 idle)
    lc_state_i   = 3'd2;
    req_target_i = {3'd0, 3'd3};
    req_token_i  = {32'h0, 32'hDEAD_0000};
    req_valid_i  = 2'b01;
    step();
    chk("tok_gnt", gnt_o, 2'b01);
    step();
    chk("tok_resp_valid", resp_valid_o, 1);
    chk("tok_resp_err", resp_err_o, 2);
    chk("tok_otp_req", otp_req_o, 0);
    req_valid_i = 2'b00;
    step();

    // Same request with matching token
    req_token_i = {32'h0, 32'hBEEF_0001};
    req_valid_i = 2'b01;
    step();
    chk("tokok_gnt", gnt_o, 2'b01);
    step();
    chk("tokok_otp_req", otp_req_o, 1);
    chk("tokok_otp_state", otp_state_o, 3);
    otp_ack_i = 1'b1;
    step();
    otp_ack_i   = 1'b0;
    req_valid_i = 2'b00;
    chk("tokok_resp_valid", resp_valid_o, 1);
    chk("tokok_resp_err", resp_err_o, 0);
    step();
    chk("tokok_locked", locked_o, 1);

    // OTP timeout: TestUnlocked0 -> TestLocked0, never acked
    do_reset();
    lc_state_i   = 3'd1;
    req_target_i = {3'd0, 3'd2};
    req_valid_i  = 2'b01;
    step();
    chk("to_gnt", gnt_o, 2'b01);
    step();
    n = 0;
    for (int i = 0; i < 200 && otp_req_o; i++) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 64);
    chk("to_resp_valid", resp_valid_o, 1);
    chk("to_resp_err", resp_err_o, 4);
    req_valid_i = 2'b00;
    step();
    chk("to_busy", busy_o, 0);
    chk("to_locked", locked_o, 0);

    // OTP error (pointer at 1, req1 idle so req0 granted)
    req_valid_i = 2'b01;
    step();
    chk("oe_gnt", gnt_o, 2'b01);
    step();
    chk("oe_otp_req", otp_req_o, 1);
    otp_ack_i = 1'b1;
    otp_err_i = 1'b1;
    step();
    otp_ack_i   = 1'b0;
    otp_err_i   = 1'b0;
    req_valid_i = 2'b00;
    chk("oe_resp_valid", resp_valid_o, 1);
    chk("oe_resp_err", resp_err_o, 3);
    step();
    chk("oe_locked", locked_o, 0);

    // Fairness: both held, both illegal, grants alternate
    do_reset();
    lc_state_i   = 3'd0;
    req_target_i = {3'd3, 3'd3};
    req_valid_i  = 2'b11;
    for (int r = 0; r < 4; r++) begin
      step();
      chk($sformatf("fair_gnt%0d", r), gnt_o, (r % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk($sformatf("fair_err%0d", r), resp_err_o, 1);
      step();
      chk($sformatf("fair_gap%0d", r), gnt_o, 0);
    end
    req_valid_i = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
